// File: rtl/seg_digit_scanner.sv
// ============================================================================
// Module   : seg_digit_scanner
// Brief    : Eight 4-bit digit registers with a write port, plus a prescaled
//            rotating mux select and active-low anode enables for the display.
//            Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_digit_scanner #(
    parameter int CLK_DIV    = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        clr,
    output logic [31:0] digits,
    output logic [2:0]  sel,
    output logic [7:0]  an,
    output logic        scan_tick,
    output logic        wr_err
);

    localparam int                 c_PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX  = c_PRE_W'(CLK_DIV - 1);
    localparam logic [2:0]         c_LAST_SEL = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]         c_NUM      = 4'(NUM_DIGITS);

    logic [c_PRE_W-1:0] r_pre;
    logic [2:0]         r_sel;
    logic [3:0]         r_digit [8];
    logic               r_wr_err;
    logic               w_addr_ok;
    logic               w_tick;
    logic [7:0]         w_an;

    assign w_addr_ok = ({1'b0, wr_addr} < c_NUM);
    assign w_tick    = (r_pre == c_PRE_MAX);

    // Prescaler and scan index; tick is the last cycle of each digit slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_sel <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_sel <= (r_sel == c_LAST_SEL) ? 3'd0 : r_sel + 3'd1;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // Digit storage: clear has priority over a write in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_digit[i] <= 4'd0;
            end
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en & ~w_addr_ok;
            if (clr) begin
                for (int i = 0; i < 8; i++) begin
                    r_digit[i] <= 4'd0;
                end
            end else if (wr_en && w_addr_ok) begin
                r_digit[wr_addr] <= wr_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pack
            assign digits[4*gi +: 4] = r_digit[gi];
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [2:0] w_msd;

    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_digit[i] != 4'd0) begin
                w_msd = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        w_an = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if ((i < NUM_DIGITS) && (r_sel == 3'(i))) begin
                w_an[i] = 1'b0;
            end
        end
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // Digit 0 is never above the msd, so it is always shown.
        if (r_sel > w_msd) begin
            w_an = 8'hFF;
        end
`endif
    end

    assign sel       = r_sel;
    assign an        = w_an;
    assign scan_tick = w_tick;
    assign wr_err    = r_wr_err;

endmodule

`default_nettype wire

// File: tb/tb_seg_digit_scanner.sv
// ============================================================================
// Module   : tb_seg_digit_scanner
// Brief    : Scoreboard bench for seg_digit_scanner on three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_digit_scanner;

    localparam int c_NI = 3;
    localparam int c_DIV [c_NI] = '{4, 4, 1};
    localparam int c_N   [c_NI] = '{8, 5, 3};

    typedef struct {
        logic [2:0][31:0] dig;
        logic [2:0][2:0]  sel;
        logic [2:0][7:0]  an;
        logic [2:0]       tick;
        logic [2:0]       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [3:0]  wr_data = 4'd0;
    logic        clr = 1'b0;

    logic [31:0] o_dig  [c_NI];
    logic [2:0]  o_sel  [c_NI];
    logic [7:0]  o_an   [c_NI];
    logic        o_tick [c_NI];
    logic        o_err  [c_NI];

    int   n_chk = 0;
    int   n_err = 0;
    int   m_cyc = 0;
    logic [3:0] m_dig [c_NI][8];
    logic       m_err [c_NI];
    exp_t sb [$];
    exp_t e_mon;

    always #5 clk = ~clk;

    seg_digit_scanner #(.CLK_DIV(4), .NUM_DIGITS(8)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr),
        .digits(o_dig[0]), .sel(o_sel[0]), .an(o_an[0]), .scan_tick(o_tick[0]), .wr_err(o_err[0]));

    seg_digit_scanner #(.CLK_DIV(4), .NUM_DIGITS(5)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr),
        .digits(o_dig[1]), .sel(o_sel[1]), .an(o_an[1]), .scan_tick(o_tick[1]), .wr_err(o_err[1]));

    seg_digit_scanner #(.CLK_DIV(1), .NUM_DIGITS(3)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr),
        .digits(o_dig[2]), .sel(o_sel[2]), .an(o_an[2]), .scan_tick(o_tick[2]), .wr_err(o_err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_an(input int s, input int n, input int k);
        logic [7:0] a;
        int         msd;
        a    = 8'hFF;
        a[s] = 1'b0;
        msd  = 0;
        for (int i = 1; i < n; i++) begin
            if (m_dig[k][i] != 4'd0) msd = i;
        end
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (s > msd) a = 8'hFF;
`endif
        return a;
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        int   s;
        for (int k = 0; k < c_NI; k++) begin
            s = (m_cyc / c_DIV[k]) % c_N[k];
            for (int i = 0; i < 8; i++) e.dig[k][4*i +: 4] = m_dig[k][i];
            e.sel[k]  = 3'(s);
            e.an[k]   = exp_an(s, c_N[k], k);
            e.tick[k] = ((m_cyc % c_DIV[k]) == c_DIV[k] - 1);
            e.err[k]  = m_err[k];
        end
        return e;
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        for (int k = 0; k < c_NI; k++) begin
            m_err[k] = 1'b0;
            for (int i = 0; i < 8; i++) m_dig[k][i] = 4'd0;
        end
    endtask

    // Drives one cycle of stimulus and queues what each DUT must show after the edge.
    task automatic step(input logic we, input logic [2:0] a, input logic [3:0] d, input logic c);
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        clr     = c;
        for (int k = 0; k < c_NI; k++) begin
            m_err[k] = we && (int'(a) >= c_N[k]);
            if (c) begin
                for (int i = 0; i < 8; i++) m_dig[k][i] = 4'd0;
            end else if (we && (int'(a) < c_N[k])) begin
                m_dig[k][a] = d;
            end
        end
        m_cyc++;
        sb.push_back(make_exp());
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            for (int k = 0; k < c_NI; k++) begin
                check($sformatf("u%0d.digits@%0d", k, m_cyc), o_dig[k], e_mon.dig[k]);
                check($sformatf("u%0d.sel@%0d", k, m_cyc), 32'(o_sel[k]), 32'(e_mon.sel[k]));
                check($sformatf("u%0d.an@%0d", k, m_cyc), 32'(o_an[k]), 32'(e_mon.an[k]));
                check($sformatf("u%0d.tick@%0d", k, m_cyc), 32'(o_tick[k]), 32'(e_mon.tick[k]));
                check($sformatf("u%0d.wr_err@%0d", k, m_cyc), 32'(o_err[k]), 32'(e_mon.err[k]));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < c_NI; k++) begin
            check($sformatf("u%0d.rst_digits", k), o_dig[k], 32'h0);
            check($sformatf("u%0d.rst_sel", k), 32'(o_sel[k]), 32'h0);
            check($sformatf("u%0d.rst_wr_err", k), 32'(o_err[k]), 32'h0);
        end
        rst = 1'b0;
        #1;
        check("u0.an_after_release", 32'(o_an[0]), 32'hFE);

        // Free-running scan past one full wrap.
        idle(34);

        // Consecutive writes 1..8 to addresses 0..7.
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 4'(i + 1), 1'b0);
        idle(1);
        check("u0.readback", o_dig[0], 32'h87654321);

        // Out-of-range write on the five-digit instance.
        step(1'b1, 3'd6, 4'hF, 1'b0);
        idle(2);

        // Clear beats a write in the same cycle.
        step(1'b1, 3'd2, 4'h9, 1'b1);
        idle(1);
        check("u0.clr_priority", o_dig[0], 32'h0);

        // Pattern 0x340 for leading-zero behaviour, then cleared.
        step(1'b1, 3'd1, 4'h4, 1'b0);
        step(1'b1, 3'd2, 4'h3, 1'b0);
        idle(34);
        step(1'b0, 3'd0, 4'd0, 1'b1);
        idle(34);

        // Reload digits, run to sel=5 on the first instance, then reset between edges.
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 4'(8 - i), 1'b0);
        for (int i = 0; i < 40 && ((m_cyc / 4) % 8) != 5; i++) idle(1);
        check("u0.sel_before_rst", 32'(o_sel[0]), 32'd5);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < c_NI; k++) begin
            check($sformatf("u%0d.async_sel", k), 32'(o_sel[k]), 32'h0);
            check($sformatf("u%0d.async_digits", k), o_dig[k], 32'h0);
        end
        #1 rst = 1'b0;
        model_reset();
        idle(10);

        // Random mix of writes, bad addresses and clears.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_digit_scanner.md
Name: seg_digit_scanner

Overview:
Writer/scan side of the 8-digit display path. Holds eight 4-bit digit registers loaded through a simple address/data write port. Presents the digits as a packed bus that feeds the 8-to-1 digit mux inputs A..H. Generates the rotating 3-bit select for that mux plus active-low anode enables, advanced by a clock prescaler.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot; legal range 1..2^20.
NUM_DIGITS, 8, number of active digits; legal range 1..8. Scan wraps at NUM_DIGITS-1.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe, one digit per cycle
wr_addr  input  3  target digit index
wr_data  input  4  nibble to store
clr  input  1  synchronous clear of all digit registers
digits  output  32  packed digits; digit i at [4i+3:4i]; wire [3:0]→A … [31:28]→H
sel  output  3  current scan index, to mux sel
an  output  8  anode enables, active-low, one-hot-zero
scan_tick  output  1  high in the cycle before sel advances
wr_err  output  1  one-cycle pulse, out-of-range write

Behaviour:
- Reset (async, rst=1): all digit regs 0, digits=32'h0, sel=0, prescaler=0, wr_err=0. an=8'hFE once rst is deasserted and sel=0.
- Prescaler:
  - Counts 0..CLK_DIV-1, then returns to 0.
  - scan_tick = (prescaler==CLK_DIV-1), combinational from the registered count.
  - CLK_DIV=1: scan_tick constantly 1; sel advances every cycle.
- Scan:
  - On an edge where scan_tick=1: sel <= (sel==NUM_DIGITS-1) ? 0 : sel+1.
  - Each digit is held for exactly CLK_DIV cycles.
  - NUM_DIGITS=1: sel stays 0.
- an:
  - Combinational from sel: an[i]=0 only for i==sel.
  - an[i]=1 always for i>=NUM_DIGITS.
  - Changes in the same cycle as sel; no glitch path beyond decode.
- Write:
  - wr_en=1 with wr_addr<NUM_DIGITS: digit[wr_addr] <= wr_data at that edge. Visible on digits the next cycle, i.e. 1-cycle latency.
  - wr_en=1 with wr_addr>=NUM_DIGITS: no register changes; wr_err=1 for the next cycle only.
  - Writes do not disturb the prescaler or sel.
  - A write to the currently selected digit shows on the mux output the next cycle.
- clr: all digit regs <= 0 at the edge.
  - clr and wr_en in the same cycle: clr wins; the write is dropped; wr_err still pulses if the address is out of range.
- Back-to-back writes on consecutive cycles are all accepted; there is no backpressure.
- Reset mid-scan: sel, prescaler and digits return to reset values immediately. The scan restarts at digit 0 with a full CLK_DIV slot.
- Scan counter and write path are independent; a scan_tick and a write on the same edge both take effect.

Optional Feature:
Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - msd = highest index i<NUM_DIGITS with digit[i]!=0; msd=0 if all digits are zero.
  - While sel>msd, an is forced to 8'hFF (digit blanked).
  - Digit 0 is never blanked.
  - Scan timing and sel sequence are unchanged.
  - Blanking follows digit register contents with the same 1-cycle write latency.
- Not defined: no blanking logic is present; an is purely the decode of sel.

Test Plan:
- Reset/scan, CLK_DIV=4, NUM_DIGITS=8: release rst → sel=0 and an=8'hFE for 4 cycles, then sel=1 and an=8'hFD. Sequence reaches sel=7 (an=8'h7F), wraps to 0 after 32 cycles total; scan_tick high 1 cycle in every 4.
- Write/readback: write addr0..7 with data 1..8 on 8 consecutive cycles → digits=32'h87654321 one cycle after the last write; sel/an timing unaffected.
- Boundary, NUM_DIGITS=5: sel cycles 0..4 and wraps. Write addr 6 data 4'hF → digits unchanged, wr_err=1 for exactly one cycle. an[7:5] stay 1.
- Clear priority: digits=32'h87654321, same cycle clr=1, wr_en=1, addr 2, data 4'h9 → digits=32'h0 next cycle.
- Async reset mid-scan: assert rst between clock edges while sel=5 with nonzero digits → sel=0 and digits=0 without a clock edge. After release, the first slot lasts 4 cycles.
- With SEG_LEADING_ZERO_BLANK_EN, digits=32'h00000340: an=8'hFE at sel=0, 8'hFD at sel=1, 8'hFB at sel=2, 8'hFF at sel=3..7. After clr, only digit 0 is displayed (an=8'hFE at sel=0, 8'hFF elsewhere).
